// File: rtl/rram_result_reader_if.sv
// rtl/rram_result_reader_if.sv - Wishbone slave-port signal bundle for rram_result_reader
interface rram_result_reader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rram_result_reader.sv
// rtl/rram_result_reader.sv - Wishbone responder popping the RRAM ADC/CSA result FIFOs
// Optional RESULT_IRQ_EN: registered result-available interrupt on irq.
module rram_result_reader #(
  parameter logic [31:0] ADDR_ADC    = 32'h3000_0010,
  parameter logic [31:0] ADDR_CSA    = 32'h3000_0014,
  parameter logic [31:0] ADDR_STATUS = 32'h3000_0018,
  parameter int          RD_LAT      = 2,
  parameter logic [31:0] EMPTY_WORD  = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  rram_result_reader_if.slave  wb,
  input  logic [31:0]          fifo_rdata,
  input  logic                 adc_empty,
  input  logic                 csa_empty,
  output logic                 rd_sync_fifo_output_buffer_ADC,
  output logic                 rd_sync_fifo_output_buffer_CSA,
  output logic                 irq
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        r_state, w_next;
  logic          r_sel_csa;
  logic          r_aborted;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_data;
  logic          r_uf_adc, r_uf_csa, r_abort;
  logic [15:0]   r_pop_count;

  logic        w_idle_req, w_hit_adc, w_hit_csa, w_hit_stat, w_hit, w_rd;
  logic        w_pop, w_empty_adc, w_empty_csa, w_stat_rd, w_stat_wr;
  logic        w_cnt_done, w_drop;
  logic        w_clr_uf_adc, w_clr_uf_csa, w_clr_abort, w_clr_cnt;
  logic [31:0] w_status;
  logic [31:0] w_unused_dat;

  assign w_idle_req  = (r_state == IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i;
  assign w_hit_adc   = (wb.wbs_adr_i == ADDR_ADC);
  assign w_hit_csa   = (wb.wbs_adr_i == ADDR_CSA);
  assign w_hit_stat  = (wb.wbs_adr_i == ADDR_STATUS);
  assign w_hit       = w_hit_adc || w_hit_csa || w_hit_stat;
  assign w_rd        = w_idle_req && !wb.wbs_we_i;
  assign w_pop       = w_rd && ((w_hit_adc && !adc_empty) || (w_hit_csa && !csa_empty));
  assign w_empty_adc = w_rd && w_hit_adc && adc_empty;
  assign w_empty_csa = w_rd && w_hit_csa && csa_empty;
  assign w_stat_rd   = w_rd && w_hit_stat;
  assign w_stat_wr   = w_idle_req && wb.wbs_we_i && w_hit_stat;
  assign w_cnt_done  = (r_state == WAIT) && (r_cnt == CW'(RD_LAT - 1));
  assign w_drop      = ((r_state == ISSUE) || (r_state == WAIT)) && !wb.wbs_cyc_i;

  assign w_clr_uf_adc = w_stat_wr && wb.wbs_dat_i[31];
  assign w_clr_uf_csa = w_stat_wr && wb.wbs_dat_i[30];
  assign w_clr_abort  = w_stat_wr && wb.wbs_dat_i[29];
  assign w_clr_cnt    = w_stat_wr && wb.wbs_dat_i[16];
  assign w_unused_dat = wb.wbs_dat_i;

  assign w_status = {r_uf_adc, r_uf_csa, r_abort, 3'b000,
                     adc_empty, csa_empty, 8'h00, r_pop_count};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_idle_req && w_hit) w_next = w_pop ? ISSUE : ACK;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_cnt_done) w_next = (r_aborted || w_drop) ? IDLE : ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset kills them at once.
  assign rd_sync_fifo_output_buffer_ADC = (r_state == ISSUE) && !r_sel_csa;
  assign rd_sync_fifo_output_buffer_CSA = (r_state == ISSUE) &&  r_sel_csa;
  assign wb.wbs_ack_o = (r_state == ACK);
  assign wb.wbs_dat_o = (r_state == ACK) ? r_data : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_sel_csa   <= 1'b0;
      r_aborted   <= 1'b0;
      r_cnt       <= '0;
      r_data      <= 32'h0;
      r_uf_adc    <= 1'b0;
      r_uf_csa    <= 1'b0;
      r_abort     <= 1'b0;
      r_pop_count <= 16'h0;
    end else begin
      r_state <= w_next;
      if (w_idle_req && w_hit) begin
        r_sel_csa <= w_hit_csa;
        r_aborted <= 1'b0;
        if (w_empty_adc || w_empty_csa) r_data <= EMPTY_WORD;
        else if (w_stat_rd)             r_data <= w_status;
        else                            r_data <= 32'h0;
      end
      if (r_state == ISSUE) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_drop) r_aborted <= 1'b1;
      if (w_cnt_done) r_data <= fifo_rdata;

      // Clears win over a same-cycle set or increment.
      if (w_clr_uf_adc)     r_uf_adc <= 1'b0;
      else if (w_empty_adc) r_uf_adc <= 1'b1;
      if (w_clr_uf_csa)     r_uf_csa <= 1'b0;
      else if (w_empty_csa) r_uf_csa <= 1'b1;
      if (w_clr_abort)      r_abort  <= 1'b0;
      else if (w_drop)      r_abort  <= 1'b1;
      if (w_clr_cnt)        r_pop_count <= 16'h0;
      else if (w_cnt_done)  r_pop_count <= r_pop_count + 16'h1;
    end
  end

`ifdef RESULT_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= ~adc_empty | ~csa_empty;
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_rram_result_reader.sv
// tb/tb_rram_result_reader.sv - scoreboard bench for rram_result_reader
module tb_rram_result_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_rdata;
  logic        adc_empty, csa_empty;
  logic        rd_adc, rd_csa, irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  rram_result_reader_if wb();

  rram_result_reader dut (
    .clk(clk), .rst(rst), .wb(wb), .fifo_rdata(fifo_rdata),
    .adc_empty(adc_empty), .csa_empty(csa_empty),
    .rd_sync_fifo_output_buffer_ADC(rd_adc),
    .rd_sync_fifo_output_buffer_CSA(rd_csa), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && wb.wbs_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'h1, 32'h0);
      end else begin
        chk("ack_data", wb.wbs_dat_o, sb_q.pop_front());
      end
    end
    if (rd_adc === 1'b1 || rd_csa === 1'b1) chk("strobe_exclusive", {31'h0, rd_adc & rd_csa}, 32'h0);
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input bit exp_ack, input logic [31:0] exp_dat, input int exp_lat,
                         input int exp_adc, input int exp_csa, input string name);
    int lat = 0, n_adc = 0, n_csa = 0, first = 0, k = 0, limit;
    bit got = 0;
    limit = exp_ack ? 20 : 8;
    @(negedge clk);
    if (exp_ack) sb_q.push_back(exp_dat);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;
    while (!got && k < limit) begin
      @(negedge clk);
      k++;
      if (rd_adc) begin n_adc++; if (first == 0) first = k; end
      if (rd_csa) begin n_csa++; if (first == 0) first = k; end
      if (wb.wbs_ack_o) begin got = 1; lat = k; end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    if (exp_ack) chk({name, "_lat"}, got ? lat : -1, exp_lat);
    else         chk({name, "_noack"}, {31'h0, got}, 32'h0);
    chk({name, "_n_rd_adc"}, n_adc, exp_adc);
    chk({name, "_n_rd_csa"}, n_csa, exp_csa);
    if (exp_adc + exp_csa > 0) chk({name, "_rd_cycle"}, first, 1);
  endtask

  localparam logic [31:0] A_ADC = 32'h3000_0010;
  localparam logic [31:0] A_CSA = 32'h3000_0014;
  localparam logic [31:0] A_ST  = 32'h3000_0018;

  initial begin
    int n_adc;
    bit got_ack;
    rst = 1'b0;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
    fifo_rdata = 32'h0; adc_empty = 1'b1; csa_empty = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
    chk("reset_dat", wb.wbs_dat_o, 32'h0);
    chk("reset_strobes", {30'h0, rd_adc, rd_csa}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b1;

    wb_xfer(0, A_ST, 0, 1, 32'h0300_0000, 1, 0, 0, "st_after_reset");

    adc_empty = 1'b0; fifo_rdata = 32'h1234_5678;
    wb_xfer(0, A_ADC, 0, 1, 32'h1234_5678, 4, 1, 0, "pop_adc");
    wb_xfer(0, A_ST, 0, 1, 32'h0100_0001, 1, 0, 0, "st_cnt1");

    wb_xfer(0, A_CSA, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, "empty_csa");
    wb_xfer(0, A_ST, 0, 1, 32'h4100_0001, 1, 0, 0, "st_uf_csa");

    fifo_rdata = 32'hA5A5_0F0F;
    wb_xfer(0, A_ADC, 0, 1, 32'hA5A5_0F0F, 4, 1, 0, "pop_adc2");
    wb_xfer(1, A_ST, 32'hE001_0000, 1, 32'h0, 1, 0, 0, "st_clear");
    wb_xfer(0, A_ST, 0, 1, 32'h0100_0000, 1, 0, 0, "st_cleared");

    // Abort: drop cyc in cycle 2 of an ADC pop.
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = A_ADC;
    n_adc = 0; got_ack = 0;
    @(negedge clk); if (rd_adc) n_adc++;
    @(negedge clk); if (rd_adc) n_adc++;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rd_adc) n_adc++;
      if (wb.wbs_ack_o) got_ack = 1;
    end
    chk("abort_n_rd_adc", n_adc, 1);
    chk("abort_noack", {31'h0, got_ack}, 32'h0);
    wb_xfer(0, A_ST, 0, 1, 32'h2100_0001, 1, 0, 0, "st_abort");

    wb_xfer(1, A_ADC, 32'hFFFF_FFFF, 1, 32'h0, 1, 0, 0, "wr_adc");
    wb_xfer(0, 32'h3000_001C, 0, 0, 32'h0, 0, 0, 0, "unmatched");

    csa_empty = 1'b0; fifo_rdata = 32'hCAFE_0001;
    wb_xfer(0, A_CSA, 0, 1, 32'hCAFE_0001, 4, 0, 1, "pop_csa");
    adc_empty = 1'b1;
    wb_xfer(0, A_ADC, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, "empty_adc");
    wb_xfer(0, A_ST, 0, 1, 32'hA200_0002, 1, 0, 0, "st_uf_adc");
    wb_xfer(1, A_ST, 32'h2000_0000, 1, 32'h0, 1, 0, 0, "st_clr_abort");
    wb_xfer(0, A_ST, 0, 1, 32'h8200_0002, 1, 0, 0, "st_abort_clr");

    // Reset asserted while the pop sits in WAIT.
    adc_empty = 1'b0;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = A_ADC;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_wait_strobes", {30'h0, rd_adc, rd_csa}, 32'h0);
    chk("rst_wait_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    adc_empty = 1'b1; csa_empty = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    wb_xfer(0, A_ST, 0, 1, 32'h0300_0000, 1, 0, 0, "st_after_rst2");

    @(negedge clk);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    csa_empty = 1'b0;
    #1;
    chk("irq_before_edge", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
`ifdef RESULT_IRQ_EN
    chk("irq_set", {31'h0, irq}, 32'h1);
`else
    chk("irq_off", {31'h0, irq}, 32'h0);
`endif
    csa_empty = 1'b1;

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
